// File: rtl/iter_divider_param.sv
// Radix-2 restoring divider: one quotient bit per clock, WIDTH-bit operands,
// optional two's-complement mode, valid/ready handshake on both sides.
module iter_divider_param #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;     // partial remainder (always < divisor)
  logic [WIDTH-1:0] acc_q, acc_d;       // dividend bits out, quotient bits in
  logic [WIDTH-1:0] dsr_q, dsr_d;       // divisor magnitude
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] quo_out_q, quo_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dz_q, dz_d;

  logic             dvd_neg, dsr_neg;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] prem_step, acc_step;
  logic [WIDTH-1:0] quo_final, rem_final;

  if (SIGNED) begin : g_signed
    assign dvd_neg = i_dividend[WIDTH-1];
    assign dsr_neg = i_divisor[WIDTH-1];
  end else begin : g_unsigned
    assign dvd_neg = 1'b0;
    assign dsr_neg = 1'b0;
  end

  // Negating MIN yields 2^(WIDTH-1), which is exact when read as unsigned.
  assign dvd_mag = dvd_neg ? (-i_dividend) : i_dividend;
  assign dsr_mag = dsr_neg ? (-i_divisor) : i_divisor;

  // One restoring step; the extra top bit of the shifted value keeps the
  // comparison exact for divisors with their MSB set.
  assign shifted   = {prem_q, acc_q[WIDTH-1]};
  assign fits      = shifted >= {1'b0, dsr_q};
  assign prem_step = fits ? WIDTH'(shifted - {1'b0, dsr_q}) : shifted[WIDTH-1:0];
  assign acc_step  = {acc_q[WIDTH-2:0], fits};

  assign quo_final = neg_quo_q ? (-acc_step) : acc_step;
  assign rem_final = neg_rem_q ? (-prem_step) : prem_step;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prem_q    <= '0;
      acc_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prem_q    <= prem_d;
      acc_q     <= acc_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dz_q      <= dz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prem_d    = prem_q;
    acc_d     = acc_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dz_d      = dz_q;

    case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          ready_d = 1'b0;
          dz_d    = 1'b0;
          if (i_divisor == '0) begin
            state_d   = DONE;
            valid_d   = 1'b1;
            dz_d      = 1'b1;
            quo_out_d = '1;
            rem_out_d = i_dividend;
          end else if (dvd_mag < dsr_mag) begin
            state_d   = DONE;
            valid_d   = 1'b1;
            quo_out_d = '0;
            rem_out_d = i_dividend;
          end else begin
            state_d   = CALC;
            cnt_d     = CW'(WIDTH - 1);
            prem_d    = '0;
            acc_d     = dvd_mag;
            dsr_d     = dsr_mag;
            neg_quo_d = dvd_neg ^ dsr_neg;
            neg_rem_d = dvd_neg;
          end
        end
      end
      CALC: begin
        prem_d = prem_step;
        acc_d  = acc_step;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d   = DONE;
          valid_d   = 1'b1;
          quo_out_d = quo_final;
          rem_out_d = rem_final;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  assign o_ready     = ready_q;
  assign o_valid     = valid_q;
  assign o_quotient  = quo_out_q;
  assign o_remainder = rem_out_q;
  assign o_div_zero  = dz_q;

endmodule
